// File: rtl/wormy_game.sv
// wormy_game: snake game core on a 16x16 grid, streaming one X/Y point per clock to two 4-bit DACs
// Ports:
//   io_in[0]    clock, all state on the rising edge
//   io_in[1]    reset, synchronous active-high
//   io_in[5:2]  buttons 0 up, 1 down, 2 left, 3 right (active-high)
//   io_in[7:6]  unused
//   io_out[3:0] X of the current display point
//   io_out[7:4] Y of the current display point
// Option: define WORMY_WALL_DEATH_EN to end the game when the head leaves the grid
//   instead of wrapping modulo 16.
module wormy_game #(
    parameter int MAX_LEN     = 8,
    parameter int TICK_CYCLES = 1024,
    parameter int INIT_LEN    = 3
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);
    localparam logic [LW-1:0] LEN_INIT  = LW'(INIT_LEN);
    localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;

    typedef enum logic [1:0] {PLAY, GAME_OVER, ARMED} state_t;

    logic          clk, rst, unused_io;
    logic [3:0]    btn;
    state_t        state_q;
    logic [1:0]    dir_q, pend_q, req, cur_dir;
    logic [LW-1:0] len_q, slot_q;
    logic [TW-1:0] tick_q;
    // Points are packed {Y, X}, the same layout as io_out and the LFSR food value.
    logic [7:0]    seg_q [MAX_LEN];
    logic [7:0]    food_q, lfsr_q, new_head, pt;
    logic          move, hit, eat, wall, fb;

    assign clk       = io_in[0];
    assign rst       = io_in[1];
    assign btn       = io_in[5:2];
    assign unused_io = &{1'b0, io_in[7:6]};

    always_comb begin
        req      = btn[0] ? UP : btn[1] ? DOWN : btn[2] ? LEFT : RIGHT;
        move     = state_q == PLAY && tick_q == TICK_LAST;
        // On a move clock the pending direction becomes current, so reversal is judged against it.
        cur_dir  = move ? pend_q : dir_q;
        new_head = {seg_q[0][7:4] + 4'(pend_q == UP) - 4'(pend_q == DOWN),
                    seg_q[0][3:0] + 4'(pend_q == RIGHT) - 4'(pend_q == LEFT)};
`ifdef WORMY_WALL_DEATH_EN
        wall = (pend_q == RIGHT && seg_q[0][3:0] == 4'hF) || (pend_q == LEFT && seg_q[0][3:0] == 4'h0) ||
               (pend_q == UP && seg_q[0][7:4] == 4'hF) || (pend_q == DOWN && seg_q[0][7:4] == 4'h0);
`else
        wall = 1'b0;
`endif
        // The tail segment vacates during the move, so only seg0..seg[len-2] can be hit.
        hit = wall;
        for (int i = 0; i < MAX_LEN - 1; i++)
            if (LW'(i + 1) < len_q && seg_q[i] == new_head) hit = 1'b1;
        eat = new_head == food_q;
        fb  = ^{lfsr_q[7], lfsr_q[5:3]};
        // Slots past the live length repeat the head so the beam parks on a lit point.
        pt  = food_q;
        for (int k = 1; k <= MAX_LEN; k++)
            if (slot_q == LW'(k)) pt = LW'(k) <= len_q ? seg_q[k-1] : seg_q[0];
    end

    always_ff @(posedge clk) begin
        if (rst || (state_q == ARMED && |btn)) begin
            state_q <= PLAY;
            dir_q   <= RIGHT;
            pend_q  <= RIGHT;
            len_q   <= LEN_INIT;
            for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= {4'd8, 4'(8 - i)};
            food_q  <= 8'h8C;
            tick_q  <= '0;
            slot_q  <= '0;
            lfsr_q  <= 8'hA5;
            io_out  <= 8'h00;
        end else begin
            lfsr_q <= {lfsr_q[6:0], fb};
            tick_q <= tick_q == TICK_LAST ? '0 : tick_q + TW'(1);
            slot_q <= slot_q == LEN_MAX ? '0 : slot_q + LW'(1);
            io_out <= pt;
            if (|btn && req != (cur_dir ^ 2'd1)) pend_q <= req;
            case (state_q)
                PLAY: begin
                    if (move && hit) state_q <= GAME_OVER;
                    else if (move) begin
                        dir_q    <= pend_q;
                        seg_q[0] <= new_head;
                        for (int i = 1; i < MAX_LEN; i++) seg_q[i] <= seg_q[i-1];
                        if (eat) food_q <= lfsr_q;
                        if (eat && len_q != LEN_MAX) len_q <= len_q + LW'(1);
                    end
                end
                GAME_OVER: if (!(|btn)) state_q <= ARMED;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wormy_game.sv
// tb_wormy_game: directed checks of the wormy_game point stream (reset, eating, steering,
// wrap or wall death, self-collision with restart, reset on a move clock).
// A 16-clock move period lets one whole 9-slot frame be read between two moves.
module tb_wormy_game;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0;
    logic [7:0] io_in, io_out;
    logic [7:0] frame [9];
    int         vecs = 0, errs = 0, tick_b = 0, slot_b = 0;

    assign io_in = {2'b00, btn, rst, clk};

    wormy_game #(.MAX_LEN(8), .TICK_CYCLES(16), .INIT_LEN(3)) dut (.io_in(io_in), .io_out(io_out));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        tick_b = tick_b == 15 ? 0 : tick_b + 1;
        slot_b = slot_b == 8 ? 0 : slot_b + 1;
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        btn = 4'b0;
        step();
        step();
        rst = 1'b0;
        tick_b = 0;
        slot_b = 0;
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        step();
        btn = 4'b0;
    endtask

    task automatic wait_move();
        int last;
        do begin
            last = tick_b;
            step();
        end while (last != 15);
    endtask

    task automatic snap();
        int s;
        for (int n = 0; n < 9; n++) begin
            s = slot_b;
            step();
            frame[s] = io_out;
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp [9];
        int s;
        exp = '{8'h8C, 8'h88, 8'h87, 8'h86, 8'h88, 8'h88, 8'h88, 8'h88, 8'h88};
        rst = 1'b1;
        btn = 4'b0;
        for (int n = 0; n < 2; n++) begin
            step();
            vecs++;
            if (io_out !== 8'h00) begin errs++; $display("FAIL reset_hold%0d: got %h, want 00", n, io_out); end
        end
        rst = 1'b0;
        tick_b = 0;
        slot_b = 0;
        for (int n = 0; n < 15; n++) begin
            s = slot_b;
            step();
            vecs++;
            if (io_out !== exp[s]) begin errs++; $display("FAIL reset_stream%0d: got %h, want %h", n, io_out, exp[s]); end
        end
    endtask

    task automatic test_eat();
        logic [7:0] exp [9];
        exp = '{8'hAB, 8'h8C, 8'h8B, 8'h8A, 8'h89, 8'h8C, 8'h8C, 8'h8C, 8'h8C};
        apply_reset();
        repeat (4) wait_move();
        snap();
        for (int k = 0; k < 9; k++) begin
            vecs++;
            if (frame[k] !== exp[k]) begin errs++; $display("FAIL eat slot%0d: got %h, want %h", k, frame[k], exp[k]); end
        end
    endtask

    task automatic test_self_hit();
        logic [7:0] grow [9];
        logic [7:0] dead [9];
        grow = '{8'h01, 8'hAB, 8'hAC, 8'h9C, 8'h8C, 8'h8B, 8'hAB, 8'hAB, 8'hAB};
        dead = '{8'h01, 8'hBC, 8'hBB, 8'hAB, 8'hAC, 8'h9C, 8'hBC, 8'hBC, 8'hBC};
        press(4'b0001);
        wait_move();
        wait_move();
        press(4'b0100);
        wait_move();
        snap();
        for (int k = 0; k < 9; k++) begin
            vecs++;
            if (frame[k] !== grow[k]) begin errs++; $display("FAIL grow5 slot%0d: got %h, want %h", k, frame[k], grow[k]); end
        end
        press(4'b0001);
        wait_move();
        press(4'b1000);
        wait_move();
        btn = 4'b0010;
        wait_move();
        snap();
        for (int k = 0; k < 9; k++) begin
            vecs++;
            if (frame[k] !== dead[k]) begin errs++; $display("FAIL selfhit slot%0d: got %h, want %h", k, frame[k], dead[k]); end
        end
        wait_move();
        snap();
        for (int k = 0; k < 9; k++) begin
            vecs++;
            if (frame[k] !== dead[k]) begin errs++; $display("FAIL held slot%0d: got %h, want %h", k, frame[k], dead[k]); end
        end
        btn = 4'b0;
        repeat (3) step();
        btn = 4'b1000;
        step();
        btn = 4'b0;
        tick_b = 0;
        slot_b = 0;
        vecs++;
        if (io_out !== 8'h00) begin errs++; $display("FAIL restart_out: got %h, want 00", io_out); end
        step();
        vecs++;
        if (io_out !== 8'h8C) begin errs++; $display("FAIL restart_food: got %h, want 8c", io_out); end
        step();
        vecs++;
        if (io_out !== 8'h88) begin errs++; $display("FAIL restart_slot1: got %h, want 88", io_out); end
    endtask

    task automatic test_steer();
        logic [7:0] right1 [9];
        logic [7:0] up1 [9];
        right1 = '{8'h8C, 8'h89, 8'h88, 8'h87, 8'h89, 8'h89, 8'h89, 8'h89, 8'h89};
        up1    = '{8'h8C, 8'h99, 8'h89, 8'h88, 8'h99, 8'h99, 8'h99, 8'h99, 8'h99};
        apply_reset();
        btn = 4'b0100;
        wait_move();
        btn = 4'b0;
        snap();
        for (int k = 0; k < 9; k++) begin
            vecs++;
            if (frame[k] !== right1[k]) begin errs++; $display("FAIL reverse slot%0d: got %h, want %h", k, frame[k], right1[k]); end
        end
        press(4'b0001);
        wait_move();
        snap();
        for (int k = 0; k < 9; k++) begin
            vecs++;
            if (frame[k] !== up1[k]) begin errs++; $display("FAIL turn_up slot%0d: got %h, want %h", k, frame[k], up1[k]); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] edge15 [9];
        logic [7:0] after [9];
        edge15 = '{8'h8C, 8'h9F, 8'h9E, 8'h9D, 8'h9F, 8'h9F, 8'h9F, 8'h9F, 8'h9F};
`ifdef WORMY_WALL_DEATH_EN
        after  = '{8'h8C, 8'h9F, 8'h9E, 8'h9D, 8'h9F, 8'h9F, 8'h9F, 8'h9F, 8'h9F};
`else
        after  = '{8'h8C, 8'h90, 8'h9F, 8'h9E, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90};
`endif
        apply_reset();
        press(4'b0001);
        wait_move();
        press(4'b1000);
        repeat (7) wait_move();
        snap();
        for (int k = 0; k < 9; k++) begin
            vecs++;
            if (frame[k] !== edge15[k]) begin errs++; $display("FAIL x15 slot%0d: got %h, want %h", k, frame[k], edge15[k]); end
        end
        wait_move();
        snap();
        for (int k = 0; k < 9; k++) begin
            vecs++;
            if (frame[k] !== after[k]) begin errs++; $display("FAIL cross slot%0d: got %h, want %h", k, frame[k], after[k]); end
        end
`ifdef WORMY_WALL_DEATH_EN
        wait_move();
        snap();
        for (int k = 0; k < 9; k++) begin
            vecs++;
            if (frame[k] !== after[k]) begin errs++; $display("FAIL frozen slot%0d: got %h, want %h", k, frame[k], after[k]); end
        end
`endif
    endtask

    task automatic test_reset_midmove();
        logic [7:0] exp [4];
        exp = '{8'h8C, 8'h88, 8'h87, 8'h86};
        apply_reset();
        wait_move();
        while (tick_b != 15) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tick_b = 0;
        slot_b = 0;
        vecs++;
        if (io_out !== 8'h00) begin errs++; $display("FAIL midmove_out: got %h, want 00", io_out); end
        for (int k = 0; k < 4; k++) begin
            step();
            vecs++;
            if (io_out !== exp[k]) begin errs++; $display("FAIL midmove slot%0d: got %h, want %h", k, io_out, exp[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_eat();
        test_self_hit();
        test_steer();
        test_wrap();
        test_reset_midmove();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
